// File: rtl/serial_word_sender.sv
// Serial word sender: FIFO-buffered words shifted out as framed bits on a trigger.
// Optional PARITY_EN appends an even-parity bit to every frame.
module serial_word_sender #(
  parameter int WIDTH     = 18,
  parameter int DEPTH     = 4,
  parameter int GAP       = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                       Ten_MHz_input_clock,
  input  logic                       reset_n,
  input  logic [WIDTH-1:0]           word_in,
  input  logic                       word_valid,
  output logic                       word_ready,
  input  logic                       input_trigger,
  output logic                       output_data_1_bit,
  output logic                       data_ctrl_output,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [BW-1:0] LAST  = BW'(WIDTH-1);
  localparam logic [GW-1:0] GLAST = GW'(GAP-1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] SHIFT  = 3'd2;
`ifdef PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] GAP_S  = 3'd4;

  logic             clk;
  logic             sync1_q, sync2_q, sync3_q;
  logic             trig_edge;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ready_q, ready_d;
  logic             ovf_q, ovf_d;
  logic             push, pop;
  logic [WIDTH-1:0] head;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [BW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    nxt, idx;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic             data_q, data_d;
  logic             ctrl_q, ctrl_d;
  logic             busy_q, busy_d;
`ifdef PARITY_EN
  logic             par_q, par_d;
`endif

  assign clk = Ten_MHz_input_clock;

  // Two flops resolve metastability, the third holds history for edge detect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= input_trigger;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign trig_edge = sync2_q & ~sync3_q;

  assign push = word_valid & ready_q;
  assign pop  = (state_q == LOAD);
  assign head = mem[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    unique case (1'b1)
      push & ~pop: count_d = count_q + CW'(1);
      pop & ~push: count_d = count_q - CW'(1);
      default:     count_d = count_q;
    endcase
    ready_d = (count_d != FULL);
    ovf_d   = ovf_q | (word_valid & ~ready_q);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= word_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ready_q <= ready_d;
      ovf_q   <= ovf_d;
    end
  end

  assign nxt = cnt_q + BW'(1);
  assign idx = (MSB_FIRST != 0) ? (LAST - nxt) : nxt;

  // Next-cycle outputs are computed here so every output leaves a flop.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    data_d  = 1'b0;
    ctrl_d  = 1'b0;
`ifdef PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (trig_edge && count_q != '0) state_d = LOAD;
      end
      LOAD: begin
        word_d  = head;
        cnt_d   = '0;
        ctrl_d  = 1'b1;
        data_d  = (MSB_FIRST != 0) ? head[WIDTH-1] : head[0];
        state_d = SHIFT;
`ifdef PARITY_EN
        par_d   = ^head;
`endif
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
`ifdef PARITY_EN
          state_d = PARITY;
          ctrl_d  = 1'b1;
          data_d  = par_q;
`else
          state_d = GAP_S;
          gcnt_d  = '0;
`endif
        end else begin
          cnt_d  = nxt;
          ctrl_d = 1'b1;
          data_d = word_q[idx];
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        state_d = GAP_S;
        gcnt_d  = '0;
      end
`endif
      GAP_S: begin
        if (gcnt_q == GLAST) begin
          state_d = (count_q != '0) ? LOAD : IDLE;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      data_q  <= 1'b0;
      ctrl_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      busy_q  <= busy_d;
    end
  end

`ifdef PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) par_q <= 1'b0;
    else          par_q <= par_d;
  end
`endif

  assign word_ready        = ready_q;
  assign output_data_1_bit = data_q;
  assign data_ctrl_output  = ctrl_q;
  assign busy              = busy_q;
  assign fifo_count        = count_q;
  assign overflow          = ovf_q;

endmodule
